// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS pipeline: opcodes, the NOP word and the IF/ID FSM state type.
package cpu_defs;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_HOLD = 1'b1
  } ifid_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between the load in EX and the instruction in ID.
module load_use_detect
  import cpu_defs::*;
(
  input  logic       valid_i,
  input  logic [5:0] op_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       mem_read_i,
  input  logic [4:0] ex_rt_i,
  output logic       lu_o
);

  logic uses_rt;

  always_comb begin
    uses_rt = (op_i == OP_RTYPE) || (op_i == OP_BEQ) || (op_i == OP_BNE) || (op_i == OP_SW);
    lu_o    = valid_i && mem_read_i && (ex_rt_i != 5'd0) &&
              ((ex_rt_i == rs_i) || (uses_rt && (ex_rt_i == rt_i)));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with fetch-side hazard control (load-use, branch, exception, imem wait)
// and a saturating counter of PC-hold cycles.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_4_in,
  input  logic [31:0]      instr_in,
  input  logic             imem_ready,
  input  logic             pc_src,
  input  logic             error,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  output logic             pc_write,
  output logic             if_lw,
  output logic             pc_flush,
  output logic             id_bubble,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_4_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] stall_cnt
);
  import cpu_defs::*;

  ifid_state_e      state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  load_use_detect u_load_use_detect (
    .valid_i    (valid_q),
    .op_i       (instr_q[31:26]),
    .rs_i       (instr_q[25:21]),
    .rt_i       (instr_q[20:16]),
    .mem_read_i (id_ex_mem_read),
    .ex_rt_i    (id_ex_rt),
    .lu_o       (lu)
  );

  always_comb begin
    state_d   = RUN;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    pc_write  = 1'b1;
    if_lw     = 1'b0;
    pc_flush  = 1'b0;
    id_bubble = 1'b0;

    if (reset) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (error) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      pc_flush  = 1'b1;
      id_bubble = 1'b1;
      state_d   = EXC_HOLD;
    end else if (state_q == EXC_HOLD) begin
      // error is low here, so the hold always ends after this cycle
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      pc_flush = 1'b1;
    end else if (pc_src) begin
      // branch resolves in ID, so it outranks a load-use stall on itself
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (lu) begin
      pc_write  = 1'b0;
      if_lw     = 1'b1;
      id_bubble = 1'b1;
    end else if (!imem_ready) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      pc_write = 1'b0;
      pc_flush = 1'b1;
    end else begin
      instr_d = instr_in;
      pc4_d   = pc_4_in;
      valid_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_4_out  = pc4_q;
  assign valid_out = valid_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a default instance plus a CNT_W=4 instance for saturation.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_4_in, instr_in;
  logic        imem_ready, pc_src, error, id_ex_mem_read;
  logic [4:0]  id_ex_rt;

  logic        pc_write, if_lw, pc_flush, id_bubble, valid_out;
  logic [31:0] instr_out, pc_4_out;
  logic [15:0] stall_cnt;

  logic        pc_write4, if_lw4, pc_flush4, id_bubble4, valid_out4;
  logic [31:0] instr_out4, pc_4_out4;
  logic [3:0]  stall_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pc_4_in(pc_4_in), .instr_in(instr_in),
    .imem_ready(imem_ready), .pc_src(pc_src), .error(error),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .pc_write(pc_write), .if_lw(if_lw), .pc_flush(pc_flush), .id_bubble(id_bubble),
    .instr_out(instr_out), .pc_4_out(pc_4_out), .valid_out(valid_out), .stall_cnt(stall_cnt)
  );

  if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .pc_4_in(pc_4_in), .instr_in(instr_in),
    .imem_ready(imem_ready), .pc_src(pc_src), .error(error),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .pc_write(pc_write4), .if_lw(if_lw4), .pc_flush(pc_flush4), .id_bubble(id_bubble4),
    .instr_out(instr_out4), .pc_4_out(pc_4_out4), .valid_out(valid_out4),
    .stall_cnt(stall_cnt4)
  );

  // Inputs change 1 unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pc_src = 1'b0; error = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    imem_ready = 1'b1; instr_in = 32'h0; pc_4_in = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    instr_in = 32'h1234_5678;
    tick();
    @(negedge clk);
    n_checks++;
    if ({pc_write, if_lw, pc_flush, id_bubble} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000", {pc_write, if_lw, pc_flush, id_bubble});
    end
    n_checks++;
    if (instr_out !== 32'h0 || pc_4_out !== 32'h0 || valid_out !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_regs: got instr=%h pc4=%h v=%b cnt=%0d want 0/0/0/0",
                         instr_out, pc_4_out, valid_out, stall_cnt);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    instr_in = 32'h0128_5020; pc_4_in = 32'h0000_0004;
    tick();
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h0128_5020 || pc_4_out !== 32'h4 || valid_out !== 1'b1 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL normal: got instr=%h pc4=%h v=%b pw=%b want 01285020/4/1/1",
                         instr_out, pc_4_out, valid_out, pc_write);
    end
  endtask

  task automatic test_load_use();
    // ID holds add $10,$9,$8 from test_normal
    instr_in = 32'h1111_1111; pc_4_in = 32'h8;
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd9;
    #1;
    n_checks++;
    if ({pc_write, if_lw, id_bubble, pc_flush} !== 4'b0110) begin
      n_fail++; $display("FAIL lu_ctrl: got %b want 0110", {pc_write, if_lw, id_bubble, pc_flush});
    end
    tick();
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h0128_5020 || pc_4_out !== 32'h4 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL lu_hold: got instr=%h pc4=%h v=%b want 01285020/4/1",
                         instr_out, pc_4_out, valid_out);
    end
    n_checks++;
    if (pc_write !== 1'b1 || if_lw !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_release: got pw=%b lw=%b cnt=%0d want 1/0/1", pc_write, if_lw, stall_cnt);
    end
    // reload the add and try a load to $zero
    instr_in = 32'h0128_5020; pc_4_in = 32'h4;
    tick();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0;
    @(negedge clk);
    n_checks++;
    if (pc_write !== 1'b1 || if_lw !== 1'b0 || id_bubble !== 1'b0) begin
      n_fail++; $display("FAIL lu_rt0: got pw=%b lw=%b bub=%b want 1/0/0", pc_write, if_lw, id_bubble);
    end
    // rt match only counts for opcodes that read rt; lw $x,0($1) with ex_rt=8 must not stall
    tick();
    id_ex_mem_read = 1'b0;
    instr_in = 32'h8C28_0000;
    tick();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8;
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h8C28_0000 || pc_write !== 1'b1 || if_lw !== 1'b0) begin
      n_fail++; $display("FAIL lu_lw_rt: got instr=%h pw=%b lw=%b want 8c280000/1/0",
                         instr_out, pc_write, if_lw);
    end
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
  endtask

  task automatic test_branch();
    do_reset();
    instr_in = 32'h0128_5020; pc_4_in = 32'h4;
    tick();
    // branch in ID with a pending load-use on it: pc_src must win
    instr_in = 32'hDEAD_BEEF; pc_4_in = 32'h8;
    pc_src = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd9;
    #1;
    n_checks++;
    if (pc_write !== 1'b1 || if_lw !== 1'b0 || id_bubble !== 1'b0) begin
      n_fail++; $display("FAIL br_prio: got pw=%b lw=%b bub=%b want 1/0/0", pc_write, if_lw, id_bubble);
    end
    tick();
    pc_src = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h0 || valid_out !== 1'b0 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL br_flush: got instr=%h v=%b pw=%b want 0/0/1", instr_out, valid_out, pc_write);
    end
  endtask

  task automatic test_exception();
    do_reset();
    instr_in = 32'h0128_5020; pc_4_in = 32'h4;
    tick();
    // error with pc_src and a live load-use: only error behaviour
    error = 1'b1; pc_src = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd9;
    #1;
    n_checks++;
    if ({pc_write, if_lw, pc_flush, id_bubble} !== 4'b1011) begin
      n_fail++; $display("FAIL exc_a: got %b want 1011", {pc_write, if_lw, pc_flush, id_bubble});
    end
    tick();
    error = 1'b0; pc_src = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    instr_in = 32'h2222_2222;
    @(negedge clk);
    n_checks++;
    if (pc_flush !== 1'b1 || valid_out !== 1'b0 || pc_write !== 1'b1 || id_bubble !== 1'b0) begin
      n_fail++; $display("FAIL exc_hold: got fl=%b v=%b pw=%b bub=%b want 1/0/1/0",
                         pc_flush, valid_out, pc_write, id_bubble);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (pc_flush !== 1'b0 || valid_out !== 1'b0 || instr_out !== 32'h0) begin
      n_fail++; $display("FAIL exc_run: got fl=%b v=%b instr=%h want 0/0/0", pc_flush, valid_out, instr_out);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h2222_2222 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL exc_resume: got instr=%h v=%b want 22222222/1", instr_out, valid_out);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    imem_ready = 1'b0; instr_in = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (pc_write !== 1'b0 || pc_flush !== 1'b1 || stall_cnt !== 16'(i)) begin
        n_fail++; $display("FAIL mw_cycle%0d: got pw=%b fl=%b cnt=%0d want 0/1/%0d",
                           i, pc_write, pc_flush, stall_cnt, i);
      end
      tick();
    end
    imem_ready = 1'b1; instr_in = 32'h8C22_0000; pc_4_in = 32'h10;
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || stall_cnt !== 16'd3 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL mw_end: got v=%b cnt=%0d pw=%b want 0/3/1", valid_out, stall_cnt, pc_write);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (instr_out !== 32'h8C22_0000 || pc_4_out !== 32'h10 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL mw_capture: got instr=%h pc4=%h v=%b want 8c220000/10/1",
                         instr_out, pc_4_out, valid_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    n_checks++;
    if (stall_cnt4 !== 4'd15) begin
      n_fail++; $display("FAIL sat4: got %0d want 15", stall_cnt4);
    end
    n_checks++;
    if (stall_cnt !== 16'd20) begin
      n_fail++; $display("FAIL cnt16: got %0d want 20", stall_cnt);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (pc_write4 !== 1'b1 || pc_flush4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall_ctrl: got pw=%b fl=%b want 1/0", pc_write4, pc_flush4);
    end
    tick();
    reset = 1'b0; imem_ready = 1'b1; instr_in = 32'h4444_4444;
    @(negedge clk);
    n_checks++;
    if (stall_cnt4 !== 4'd0 || pc_flush4 !== 1'b0 || pc_write4 !== 1'b1 || valid_out4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall: got cnt=%0d fl=%b pw=%b v=%b want 0/0/1/0",
                         stall_cnt4, pc_flush4, pc_write4, valid_out4);
    end
  endtask

  task automatic test_reset_in_exc();
    do_reset();
    error = 1'b1;
    tick();
    error = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pc_flush !== 1'b0 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL rst_exc: got fl=%b pw=%b want 0/1", pc_flush, pc_write);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_branch();
    test_exception();
    test_mem_wait();
    test_saturation();
    test_reset_in_exc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
